bitfusion_column_ctrl: RTL and testbench

BITFUSION_COLUMN_CTRL -- requirements
Module: bitfusion_column_ctrl

---
 rtl/bitfusion_column_ctrl.sv | 163 ++++++++++++++++
 tb/tb_bitfusion_column_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bitfusion_column_ctrl.sv
// Sequencer for one BitFusion PE column: weight load, buffer fill, activation streaming, drain, done.
// All outputs are registered decodes of the next state; busy is high from LOAD through DONE.
module bitfusion_column_ctrl #(
  parameter int NUM_PE       = 16,
  parameter int DRAIN_CYCLES = 19,
  parameter int TILE_W       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [1:0]            cfg_bitwidth,
  input  logic [3:0]            cfg_sign_x,
  input  logic [3:0]            cfg_sign_y,
  input  logic [TILE_W-1:0]     cfg_tiles,
  output logic                  busy,
  output logic                  wbuf_load,
  output logic                  acc_clear,
  output logic                  act_valid,
  output logic [1:0]            input_bitwidth,
  output logic [3:0]            sign_x,
  output logic [3:0]            sign_y,
  output logic [3*NUM_PE-1:0]   signal,
  output logic                  done
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    FILL   = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [TILE_W-1:0]   tile_q, tile_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          bw_q, bw_d;
  logic [3:0]          sx_q, sx_d;
  logic [3:0]          sy_q, sy_d;
  logic [3*NUM_PE-1:0] signal_q, signal_d;
  logic                busy_q, busy_d;
  logic                wbuf_q, wbuf_d;
  logic                clr_q, clr_d;
  logic                act_q, act_d;
  logic                done_q, done_d;

  always_comb begin
    state_d  = state_q;
    tile_d   = tile_q;
    cnt_d    = cnt_q;
    bw_d     = bw_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    signal_d = signal_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          bw_d     = (cfg_bitwidth == 2'b11) ? 2'b10 : cfg_bitwidth;
          sx_d     = cfg_sign_x;
          sy_d     = cfg_sign_y;
          signal_d = {NUM_PE{{1'b0, bw_d}}};
          tile_d   = cfg_tiles;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        // cnt counts the two FILL cycles down as 1, 0
        cnt_d   = CNT_W'(1);
        state_d = FILL;
      end
      FILL: begin
        if (cnt_q == '0) begin
          if (tile_q == '0) begin
            cnt_d   = DRAIN_LOAD;
            state_d = DRAIN;
          end else begin
            state_d = STREAM;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STREAM: begin
        if (tile_q != '0) tile_d = tile_q - TILE_W'(1);
        if (tile_q <= TILE_W'(1)) begin
          cnt_d   = DRAIN_LOAD;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // the DONE cycle itself is the last of the DRAIN_CYCLES after the final issue
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      tile_d  = '0;
      cnt_d   = '0;
    end

    busy_d = (state_d != IDLE);
    wbuf_d = (state_d == LOAD);
    clr_d  = (state_d == LOAD);
    act_d  = (state_d == STREAM);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      tile_q   <= '0;
      cnt_q    <= '0;
      bw_q     <= 2'b00;
      sx_q     <= 4'h0;
      sy_q     <= 4'h0;
      signal_q <= '0;
      busy_q   <= 1'b0;
      wbuf_q   <= 1'b0;
      clr_q    <= 1'b0;
      act_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tile_q   <= tile_d;
      cnt_q    <= cnt_d;
      bw_q     <= bw_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      signal_q <= signal_d;
      busy_q   <= busy_d;
      wbuf_q   <= wbuf_d;
      clr_q    <= clr_d;
      act_q    <= act_d;
      done_q   <= done_d;
    end
  end

  assign busy           = busy_q;
  assign wbuf_load      = wbuf_q;
  assign acc_clear      = clr_q;
  assign act_valid      = act_q;
  assign done           = done_q;
  assign input_bitwidth = bw_q;
  assign sign_x         = sx_q;
  assign sign_y         = sy_q;
  assign signal         = signal_q;

endmodule

// File: tb/tb_bitfusion_column_ctrl.sv
// Bench for bitfusion_column_ctrl: run-level timeline model checked every cycle, plus literal timing checks.
module tb_bitfusion_column_ctrl;

  localparam int DC = 19;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort;
  logic [1:0]  cfg_bitwidth;
  logic [3:0]  cfg_sign_x, cfg_sign_y;
  logic [7:0]  cfg_tiles;
  logic        busy, wbuf_load, acc_clear, act_valid, done;
  logic [1:0]  input_bitwidth;
  logic [3:0]  sign_x, sign_y;
  logic [47:0] signal;

  bitfusion_column_ctrl #(.NUM_PE(16), .DRAIN_CYCLES(DC), .TILE_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_bitwidth(cfg_bitwidth), .cfg_sign_x(cfg_sign_x), .cfg_sign_y(cfg_sign_y),
    .cfg_tiles(cfg_tiles), .busy(busy), .wbuf_load(wbuf_load), .acc_clear(acc_clear),
    .act_valid(act_valid), .input_bitwidth(input_bitwidth), .sign_x(sign_x),
    .sign_y(sign_y), .signal(signal), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Run model: a run is "t cycles after acceptance"; LOAD at t=1, FILL t=2..3,
  // activations t=4..3+N, done DRAIN_CYCLES after the last issue at t=3+N+DC.
  logic       m_active;
  int         m_t, m_n;
  logic [1:0] m_bw;
  logic [3:0] m_sx, m_sy;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0;
      m_t      <= 0;
      m_n      <= 0;
      m_bw     <= 2'b00;
      m_sx     <= 4'h0;
      m_sy     <= 4'h0;
    end else if (m_active) begin
      if (abort || m_t == 3 + m_n + DC) m_active <= 1'b0;
      else m_t <= m_t + 1;
    end else if (start && !abort) begin
      m_active <= 1'b1;
      m_t      <= 1;
      m_n      <= int'(cfg_tiles);
      m_bw     <= (cfg_bitwidth == 2'b11) ? 2'b10 : cfg_bitwidth;
      m_sx     <= cfg_sign_x;
      m_sy     <= cfg_sign_y;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [47:0] a, input logic [47:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  // Observations of the DUT, used only for the literal timing checks.
  int   act_total = 0, done_total = 0;
  int   first_act_cyc = -1, done_cyc = -1, wbuf_cyc = -1;
  logic prev_act = 1'b0;

  task automatic compare_all();
    logic e_act, e_done, e_wbuf;
    e_wbuf = m_active && m_t == 1;
    e_act  = m_active && m_t >= 4 && m_t <= 3 + m_n;
    e_done = m_active && m_t == 3 + m_n + DC;
    chk("busy",      48'(busy),           48'(m_active));
    chk("wbuf_load", 48'(wbuf_load),      48'(e_wbuf));
    chk("acc_clear", 48'(acc_clear),      48'(e_wbuf));
    chk("act_valid", 48'(act_valid),      48'(e_act));
    chk("done",      48'(done),           48'(e_done));
    chk("bitwidth",  48'(input_bitwidth), 48'(m_bw));
    chk("sign_x",    48'(sign_x),         48'(m_sx));
    chk("sign_y",    48'(sign_y),         48'(m_sy));
    chk("signal",    signal,              48'({16{{1'b0, m_bw}}}));
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
    if (act_valid && !prev_act) first_act_cyc = cyc;
    if (act_valid) act_total++;
    if (done) begin done_total++; done_cyc = cyc; end
    if (wbuf_load) wbuf_cyc = cyc;
    prev_act = act_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int k, a0, d0;

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_bitwidth = 2'b00; cfg_sign_x = 4'h0; cfg_sign_y = 4'h0; cfg_tiles = 8'd0;
    run(3);

    // 4 tiles at 4b, start presented together with reset release
    reset = 1'b1; start = 1'b1; cfg_tiles = 8'd4; cfg_bitwidth = 2'b01;
    cfg_sign_x = 4'h5; cfg_sign_y = 4'hA;
    k = cyc; a0 = act_total; d0 = done_total;
    step(); start = 1'b0;
    run(10);
    chk("t1_signal_lit", signal, 48'h249249249249);
    run(20);
    chk("t1_wbuf_cyc",  48'(wbuf_cyc - k),      48'd1);
    chk("t1_first_act", 48'(first_act_cyc - k), 48'd4);
    chk("t1_act_count", 48'(act_total - a0),    48'd4);
    chk("t1_done_cyc",  48'(done_cyc - k),      48'd26);
    chk("t1_done_count", 48'(done_total - d0),  48'd1);

    // zero tiles at 8b
    start = 1'b1; cfg_tiles = 8'd0; cfg_bitwidth = 2'b10;
    k = cyc; a0 = act_total; d0 = done_total;
    step(); start = 1'b0;
    run(25);
    chk("t2_act_count", 48'(act_total - a0), 48'd0);
    chk("t2_done_cyc",  48'(done_cyc - k),   48'd22);

    // abort with start in IDLE, then abort in the 2nd STREAM cycle
    start = 1'b1; abort = 1'b1;
    step(); start = 1'b0; abort = 1'b0;
    chk("t3_abort_idle_busy", 48'(busy), 48'd0);
    start = 1'b1; cfg_tiles = 8'd6; cfg_bitwidth = 2'b01; cfg_sign_y = 4'h6;
    k = cyc; a0 = act_total; d0 = done_total;
    step(); start = 1'b0;
    run(4);
    abort = 1'b1;
    step(); abort = 1'b0;
    chk("t3_act_after_abort",  48'(act_valid), 48'd0);
    chk("t3_busy_after_abort", 48'(busy),      48'd0);
    run(30);
    chk("t3_act_count",  48'(act_total - a0),  48'd2);
    chk("t3_done_count", 48'(done_total - d0), 48'd0);
    start = 1'b1; cfg_tiles = 8'd1;
    k = cyc; d0 = done_total;
    step(); start = 1'b0;
    run(25);
    chk("t3_restart_done", 48'(done_total - d0), 48'd1);
    chk("t3_restart_cyc",  48'(done_cyc - k),    48'd23);

    // start held while busy, cfg_sign_x changed mid-run
    start = 1'b1; cfg_tiles = 8'd3; cfg_sign_x = 4'h3;
    k = cyc; d0 = done_total;
    run(5);
    cfg_sign_x = 4'hF; cfg_tiles = 8'd9;
    run(15);
    start = 1'b0;
    run(20);
    chk("t4_done_count", 48'(done_total - d0), 48'd1);
    chk("t4_sign_x",     48'(sign_x),          48'h3);

    // reserved width, then reset during DRAIN
    start = 1'b1; cfg_tiles = 8'd2; cfg_bitwidth = 2'b11;
    k = cyc; d0 = done_total;
    step(); start = 1'b0;
    run(2);
    chk("t5_bitwidth_lit", 48'(input_bitwidth), 48'h2);
    chk("t5_signal_lit",   signal,              48'h492492492492);
    run(7);
    #1 reset = 1'b0;
    #1;
    chk("t5_rst_busy",   48'(busy),           48'd0);
    chk("t5_rst_done",   48'(done),           48'd0);
    chk("t5_rst_bw",     48'(input_bitwidth), 48'd0);
    chk("t5_rst_sign_x", 48'(sign_x),         48'd0);
    chk("t5_rst_signal", signal,              48'd0);
    run(3);
    reset = 1'b1;
    run(25);
    chk("t5_done_count", 48'(done_total - d0), 48'd0);

    // maximum tile count
    start = 1'b1; cfg_tiles = 8'd255; cfg_bitwidth = 2'b00; cfg_sign_x = 4'h9;
    k = cyc; a0 = act_total; d0 = done_total;
    step(); start = 1'b0;
    run(280);
    chk("t6_act_count", 48'(act_total - a0), 48'd255);
    chk("t6_done_cyc",  48'(done_cyc - k),   48'd277);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
